// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
//
// Shared definitions for the calculator datapath: the button index map used by
// both the button conditioner and the calculator FSM, the button vector type
// and a helper that isolates the lowest set bit of a button vector.
//
// Contents:
//   BTN_CLR..BTN_MOD : bit positions of each command button (0 = highest prio)
//   NUM_BTN          : number of button lines
//   btn_vec_t        : one bit per button line
//   lowest_set_bit() : keeps only the lowest-index set bit of a vector
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int BTN_CLR = 0;
    localparam int BTN_ADD = 1;
    localparam int BTN_MUL = 2;
    localparam int BTN_DIV = 3;
    localparam int BTN_MOD = 4;
    localparam int NUM_BTN = 5;

    typedef logic [NUM_BTN-1:0] btn_vec_t;

    // Scans from the highest index down so the final write is the lowest set
    // bit; the result is either all-zero or strictly one-hot.
    function automatic btn_vec_t lowest_set_bit(input btn_vec_t v);
        btn_vec_t r;
        r = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
//
// Bundles the raw button pins and the conditioned outputs of the button
// conditioner.
//
// Signals:
//   btn_raw     : raw, asynchronous, active-high button pins
//   btn_level   : debounced button levels
//   cmd         : one-hot press pulse, one cycle wide, 0 when idle
//   cmd_valid   : OR of cmd, registered alongside it
//   press_count : number of accepted commands, wraps 255 -> 0
//
// Modports:
//   master : the side that owns the pins and consumes the commands
//   slave  : the conditioner itself
// -----------------------------------------------------------------------------
interface button_conditioner_if;
    import calc_pkg::*;

    btn_vec_t   btn_raw;
    btn_vec_t   btn_level;
    btn_vec_t   cmd;
    logic       cmd_valid;
    logic [7:0] press_count;

    modport master (
        output btn_raw,
        input  btn_level,
        input  cmd,
        input  cmd_valid,
        input  press_count
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output cmd,
        output cmd_valid,
        output press_count
    );

endinterface

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
//
// Conditions one raw button line: a two-flop synchroniser followed by a
// debounce counter that only accepts a level change after the synchronised
// input has disagreed with the accepted level for DEBOUNCE_CYCLES consecutive
// cycles. Any single cycle of agreement restarts the count.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive disagreeing cycles needed (must be >= 2)
//
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset
//   raw   : asynchronous raw button input
//   level : debounced level, straight from a flop
// -----------------------------------------------------------------------------
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    // Wide enough to hold DEBOUNCE_CYCLES-1, the terminal count.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // s1 -> s2 form a plain synchroniser with nothing between the flops.
    // The counter measures how long s2 has continuously disagreed with the
    // accepted level; reaching the terminal count flips the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front end for the calculator FSM. Each raw button line is synchronised and
// debounced independently; every debounced rising edge becomes a single-cycle,
// strictly one-hot command pulse. When several buttons rise in the same cycle
// only the lowest index survives and the others are dropped. Releases never
// produce commands. Every output comes straight from a flop.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive disagreeing cycles to accept a level change
//
// Ports:
//   clk : system clock (100 MHz)
//   rst : synchronous active-high reset
//   bus : slave side of button_conditioner_if
//         btn_raw in; btn_level, cmd, cmd_valid, press_count out
// -----------------------------------------------------------------------------
module button_conditioner
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    button_conditioner_if.slave   bus
);

    btn_vec_t   stable;
    btn_vec_t   stable_d;
    btn_vec_t   rise;
    btn_vec_t   cmd_q;
    logic       cmd_valid_q;
    logic [7:0] press_count_q;

    // One synchroniser/debouncer per button line.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_debounce
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.btn_raw[i]),
            .level (stable[i])
        );
    end

    // A rise is a debounced level that was low one cycle earlier. A button
    // that is already held has no rise, so it never masks a later press on a
    // different line.
    assign rise = stable & ~stable_d;

    // Edge history, priority pick and the accepted-command counter. The
    // counter follows the registered cmd_valid, so it lags the pulse by one
    // cycle and wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d      <= '0;
            cmd_q         <= '0;
            cmd_valid_q   <= 1'b0;
            press_count_q <= '0;
        end else begin
            stable_d      <= stable;
            cmd_q         <= lowest_set_bit(rise);
            cmd_valid_q   <= |rise;
            press_count_q <= press_count_q + {7'd0, cmd_valid_q};
        end
    end

    assign bus.btn_level   = stable;
    assign bus.cmd         = cmd_q;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.press_count = press_count_q;

endmodule
